// File: rtl/capture_pkg.sv
// capture_pkg: FSM state encoding and default widths shared by the capture_ring block.
package capture_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ARMED,
      POST,
      DONE
   } cap_state_t;

   localparam int CAP_DW_DEF      = 16;
   localparam int CAP_FIX_DLY_DEF = 3;

endpackage

// File: rtl/capture_dly_line.sv
// capture_dly_line: shift-register delay of a valid/data pair by FIX_DLY+trig_dly cycles.
// Only the valid column is reset, so stale data behind a reset can never be presented as valid.
module capture_dly_line
   import capture_pkg::*;
#(
   parameter int DW      = CAP_DW_DEF,
   parameter int FIX_DLY = CAP_FIX_DLY_DEF,
   parameter int DLY_AW  = 4
) (
   input  logic              core_clk,
   input  logic              core_rst_n,
   input  logic [DLY_AW-1:0] trig_dly,
   input  logic              src_vld,
   input  logic [DW-1:0]     src_data,
   output logic              dly_vld,
   output logic [DW-1:0]     dly_data
);

   localparam int MAXD = FIX_DLY + (1 << DLY_AW) - 1;
   localparam int TW   = $clog2(MAXD);

   logic [MAXD-1:0] vld_sr;
   logic [DW-1:0]   data_sr [MAXD];
   logic [TW-1:0]   tap;

   // Tap k of the shift register holds the input as it was k+1 cycles ago.
   assign tap = TW'(FIX_DLY - 1) + TW'(trig_dly);

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         vld_sr <= '0;
      end else begin
         vld_sr <= {vld_sr[MAXD-2:0], src_vld};
      end
   end

   always_ff @(posedge core_clk) begin
      data_sr[0] <= src_data;
      for (int i = 1; i < MAXD; i++) begin
         data_sr[i] <= data_sr[i-1];
      end
   end

   assign dly_vld  = vld_sr[tap];
   assign dly_data = data_sr[tap];

endmodule

// File: rtl/capture_ring.sv
// capture_ring: delays the sample stream to trigger latency, runs the pre/post-trigger ring FSM and
// reports trigger position and SDRAM start address. Define CAPTURE_OVF_EN for capture_ready/capture_ovf.
module capture_ring
   import capture_pkg::*;
#(
   parameter int DW      = CAP_DW_DEF,
   parameter int AW      = 32,
   parameter int FIX_DLY = CAP_FIX_DLY_DEF,
   parameter int DLY_AW  = 4
) (
   input  logic              core_clk,
   input  logic              core_rst_n,
   input  logic              sample_en,
   input  logic [AW-1:0]     sample_depth,
   input  logic [AW-1:0]     trig_pos,
   input  logic              trig_en,
   input  logic [DLY_AW-1:0] trig_dly,
   input  logic              sample_valid,
   input  logic [DW-1:0]     sample_data,
   input  logic              trig_hit,
`ifdef CAPTURE_OVF_EN
   input  logic              capture_ready,
   output logic              capture_ovf,
`endif
   output logic              capture_valid,
   output logic [DW-1:0]     capture_data,
   output logic              capture_done,
   output logic [AW-1:0]     trig_real_pos,
   output logic [AW-1:0]     sd_saddr
);

   localparam logic [AW-1:0] ONE              = AW'(1);
   localparam logic [AW-1:0] BYTES_PER_SAMPLE = AW'(DW / 8);

   function automatic logic [AW-1:0] sat_trig_pos(input logic [AW-1:0] pos,
                                                  input logic [AW-1:0] depth);
      return (pos >= depth) ? depth - ONE : pos;
   endfunction

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] idx,
                                              input logic [AW-1:0] depth);
      return (idx == depth - ONE) ? '0 : idx + ONE;
   endfunction

   cap_state_t    state, state_n;
   logic          sample_en_q, en_rise;
   logic          vld_p0;
   logic [DW-1:0] data_p0;
   logic [AW-1:0] tpe, post_len, arm_idx, pre_inc, post_inc;
   logic [AW-1:0] wr_idx, wr_idx_n, pre_cnt, pre_cnt_n, post_cnt, post_cnt_n;
   logic [AW-1:0] start_idx, start_idx_n, trp_n, saddr_n;
   logic          done_n, active, trig_now, take_trig, from_pre;

   // Stage p0: sample stream delayed to line up with trig_hit
   capture_dly_line #(
      .DW      (DW),
      .FIX_DLY (FIX_DLY),
      .DLY_AW  (DLY_AW)
   ) u_dly (
      .core_clk   (core_clk),
      .core_rst_n (core_rst_n),
      .trig_dly   (trig_dly),
      .src_vld    (sample_valid),
      .src_data   (sample_data),
      .dly_vld    (vld_p0),
      .dly_data   (data_p0)
   );

   assign tpe      = sat_trig_pos(trig_pos, sample_depth);
   assign post_len = sample_depth - tpe;
   assign pre_inc  = pre_cnt + ONE;
   assign post_inc = post_cnt + ONE;
   assign en_rise  = sample_en & ~sample_en_q;
   assign active   = (state == PRE) || (state == ARMED) || (state == POST);
   assign trig_now = vld_p0 & (trig_hit | ~trig_en);
   // Oldest pre-trigger slot, taken modulo depth without forming wr_idx + depth.
   assign arm_idx  = (wr_idx >= tpe) ? wr_idx - tpe : sample_depth - (tpe - wr_idx);

   always_comb begin
      state_n     = state;
      wr_idx_n    = wr_idx;
      pre_cnt_n   = pre_cnt;
      post_cnt_n  = post_cnt;
      start_idx_n = start_idx;
      trp_n       = trig_real_pos;
      saddr_n     = sd_saddr;
      done_n      = 1'b0;
      take_trig   = 1'b0;
      from_pre    = 1'b0;

      case (state)
         IDLE: begin
            if (en_rise) begin
               wr_idx_n    = '0;
               pre_cnt_n   = '0;
               post_cnt_n  = '0;
               start_idx_n = '0;
               trp_n       = '0;
               saddr_n     = '0;
               state_n     = (tpe == '0) ? ARMED : PRE;
            end
         end
         PRE: begin
            if (vld_p0) begin
               wr_idx_n = wrap_inc(wr_idx, sample_depth);
               if (pre_inc == tpe) begin
                  // The completing sample arms first; a coincident trigger is seen as ARMED.
                  pre_cnt_n = pre_inc;
                  state_n   = ARMED;
                  take_trig = trig_now;
               end else if (trig_now) begin
                  take_trig = 1'b1;
                  from_pre  = 1'b1;
               end else begin
                  pre_cnt_n = pre_inc;
               end
            end
         end
         ARMED: begin
            if (vld_p0) begin
               wr_idx_n  = wrap_inc(wr_idx, sample_depth);
               take_trig = trig_now;
            end
         end
         POST: begin
            if (vld_p0) begin
               wr_idx_n   = wrap_inc(wr_idx, sample_depth);
               post_cnt_n = post_inc;
               if (post_inc == post_len) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  saddr_n = start_idx * BYTES_PER_SAMPLE;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // The trigger sample is the first post-trigger sample.
      if (take_trig) begin
         trp_n       = from_pre ? pre_cnt : tpe;
         start_idx_n = from_pre ? '0 : arm_idx;
         post_cnt_n  = ONE;
         if (post_len == ONE) begin
            state_n = DONE;
            done_n  = 1'b1;
            saddr_n = start_idx_n * BYTES_PER_SAMPLE;
         end else begin
            state_n = POST;
         end
      end

      if ((state != IDLE) && !sample_en) begin
         state_n = IDLE;
         done_n  = 1'b0;
         trp_n   = trig_real_pos;
         saddr_n = sd_saddr;
      end
   end

   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state         <= IDLE;
         sample_en_q   <= 1'b0;
         wr_idx        <= '0;
         pre_cnt       <= '0;
         post_cnt      <= '0;
         start_idx     <= '0;
         trig_real_pos <= '0;
         sd_saddr      <= '0;
         capture_done  <= 1'b0;
      end else begin
         state         <= state_n;
         sample_en_q   <= sample_en;
         wr_idx        <= wr_idx_n;
         pre_cnt       <= pre_cnt_n;
         post_cnt      <= post_cnt_n;
         start_idx     <= start_idx_n;
         trig_real_pos <= trp_n;
         sd_saddr      <= saddr_n;
         capture_done  <= done_n;
      end
   end

   // Stage p1: registered capture output toward the memory path
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         capture_valid <= 1'b0;
         capture_data  <= '0;
      end else begin
         capture_valid <= vld_p0 & active;
         if (vld_p0 & active) begin
            capture_data <= data_p0;
         end
      end
   end

`ifdef CAPTURE_OVF_EN
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         capture_ovf <= 1'b0;
      end else if (en_rise) begin
         capture_ovf <= 1'b0;
      end else if (capture_valid & ~capture_ready) begin
         capture_ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_capture_ring.sv
// tb_capture_ring: directed scoreboard bench for capture_ring (CAPTURE_OVF_EN adds the overflow case).
module tb_capture_ring;

   localparam int DW      = 16;
   localparam int AW      = 32;
   localparam int FIX_DLY = 3;
   localparam int DLY_AW  = 4;

   logic              core_clk     = 1'b0;
   logic              core_rst_n   = 1'b1;
   logic              sample_en    = 1'b0;
   logic [AW-1:0]     sample_depth = 32'd8;
   logic [AW-1:0]     trig_pos     = 32'd0;
   logic              trig_en      = 1'b1;
   logic [DLY_AW-1:0] trig_dly     = '0;
   logic              sample_valid = 1'b0;
   logic [DW-1:0]     sample_data  = '0;
   logic              trig_hit;
   logic              capture_valid;
   logic [DW-1:0]     capture_data;
   logic              capture_done;
   logic [AW-1:0]     trig_real_pos;
   logic [AW-1:0]     sd_saddr;
`ifdef CAPTURE_OVF_EN
   logic              capture_ready = 1'b1;
   logic              capture_ovf;
`endif

   int            total        = 0;
   int            bad          = 0;
   int            cyc          = 0;
   int            last_cap_cyc = -1;
   int            done_cnt     = 0;
   logic [DW-1:0] exp_q [$];
   logic          hit_src      = 1'b0;
   logic [31:0]   hit_sr       = '0;
   logic [4:0]    hit_tap;

   capture_ring #(
      .DW      (DW),
      .AW      (AW),
      .FIX_DLY (FIX_DLY),
      .DLY_AW  (DLY_AW)
   ) dut (
      .core_clk      (core_clk),
      .core_rst_n    (core_rst_n),
      .sample_en     (sample_en),
      .sample_depth  (sample_depth),
      .trig_pos      (trig_pos),
      .trig_en       (trig_en),
      .trig_dly      (trig_dly),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .trig_hit      (trig_hit),
`ifdef CAPTURE_OVF_EN
      .capture_ready (capture_ready),
      .capture_ovf   (capture_ovf),
`endif
      .capture_valid (capture_valid),
      .capture_data  (capture_data),
      .capture_done  (capture_done),
      .trig_real_pos (trig_real_pos),
      .sd_saddr      (sd_saddr)
   );

   always #5 core_clk = ~core_clk;

   // The trigger source is delayed by the same amount as the stream so it lines up with its sample.
   always @(posedge core_clk) begin
      cyc    <= cyc + 1;
      hit_sr <= {hit_sr[30:0], hit_src};
   end
   assign hit_tap  = 5'(FIX_DLY - 1) + 5'(trig_dly);
   assign trig_hit = hit_sr[hit_tap];

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic start_cap(input logic [AW-1:0] depth, input logic [AW-1:0] tp, input logic ten);
      @(posedge core_clk); #1;
      sample_depth = depth;
      trig_pos     = tp;
      trig_en      = ten;
      sample_en    = 1'b1;
      done_cnt     = 0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic hit, input logic expect_cap);
      @(posedge core_clk); #1;
      sample_valid = 1'b1;
      sample_data  = d;
      hit_src      = hit;
      if (expect_cap) exp_q.push_back(d);
   endtask

   task automatic stop_stream();
      @(posedge core_clk); #1;
      sample_valid = 1'b0;
      hit_src      = 1'b0;
   endtask

   task automatic end_cap();
      @(posedge core_clk); #1;
      sample_en = 1'b0;
      repeat (20) @(posedge core_clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (capture_done !== 1'b1 && n < budget) begin
         @(negedge core_clk);
         n++;
      end
      total++;
      assert (capture_done === 1'b1) else begin
         bad++;
         $error("FAIL %s_done observed=%b expected=1", tag, capture_done);
      end
   endtask

   task automatic check_tail(input string tag);
      @(negedge core_clk);
      chk({tag, "_pulse"}, AW'(capture_done), 32'd0);
      chk({tag, "_left"}, AW'(exp_q.size()), 32'd0);
      chk({tag, "_ndone"}, AW'(done_cnt), 32'd1);
   endtask

   // Scoreboard: every captured sample must match the oldest outstanding expectation.
   initial begin
      logic [DW-1:0] exp_d;
      forever begin
         @(negedge core_clk);
         if (capture_done === 1'b1) done_cnt++;
         if (core_rst_n === 1'b1 && capture_valid === 1'b1) begin
            last_cap_cyc = cyc;
            total++;
            assert (exp_q.size() != 0) else begin
               bad++;
               $error("FAIL sb_unexpected observed=%h expected=no_capture", capture_data);
            end
            if (exp_q.size() != 0) begin
               exp_d = exp_q.pop_front();
               total++;
               assert (capture_data === exp_d) else begin
                  bad++;
                  $error("FAIL sb_data observed=%h expected=%h", capture_data, exp_d);
               end
            end
         end
      end
   end

   initial begin
      int n;
      int c0;

      #1 core_rst_n = 1'b0;
      repeat (3) @(posedge core_clk);
      #1;
      chk("rst_valid", AW'(capture_valid), 32'd0);
      chk("rst_data", AW'(capture_data), 32'd0);
      chk("rst_done", AW'(capture_done), 32'd0);
      chk("rst_trp", trig_real_pos, 32'd0);
      chk("rst_saddr", sd_saddr, 32'd0);
      core_rst_n = 1'b1;
      repeat (2) @(posedge core_clk);

      // depth 8, 3 pre-trigger, hit on 6th sample
      start_cap(32'd8, 32'd3, 1'b1);
      for (int i = 1; i <= 10; i++) send(DW'(16'h1100 + i), (i == 6), 1'b1);
      stop_stream();
      wait_done("t1", 40);
      chk("t1_trp", trig_real_pos, 32'd3);
      chk("t1_saddr", sd_saddr, 32'd4);
      check_tail("t1");
      end_cap();

      // hit while still in PRE on 2nd sample
      start_cap(32'd8, 32'd3, 1'b1);
      for (int i = 1; i <= 6; i++) send(DW'(16'h2200 + i), (i == 2), 1'b1);
      stop_stream();
      wait_done("t2", 40);
      chk("t2_trp", trig_real_pos, 32'd1);
      chk("t2_saddr", sd_saddr, 32'd0);
      check_tail("t2");
      end_cap();

      // immediate trigger, depth 16
      start_cap(32'd16, 32'd0, 1'b0);
      for (int i = 1; i <= 16; i++) send(DW'(16'h3300 + i), 1'b0, 1'b1);
      stop_stream();
      wait_done("t3", 40);
      chk("t3_trp", trig_real_pos, 32'd0);
      chk("t3_saddr", sd_saddr, 32'd0);
      check_tail("t3");
      end_cap();

      // trig_pos beyond depth clamps to depth-1; ring wraps; single post sample
      start_cap(32'd4, 32'd9, 1'b1);
      for (int i = 1; i <= 5; i++) send(DW'(16'h3B00 + i), (i == 5), 1'b1);
      stop_stream();
      wait_done("t3b", 40);
      chk("t3b_trp", trig_real_pos, 32'd3);
      chk("t3b_saddr", sd_saddr, 32'd2);
      check_tail("t3b");
      end_cap();

      // abort during POST
      start_cap(32'd8, 32'd2, 1'b1);
      for (int i = 1; i <= 6; i++) send(DW'(16'h5500 + i), (i == 4), 1'b1);
      stop_stream();
      repeat (12) @(negedge core_clk);
      chk("t5a_drained", AW'(exp_q.size()), 32'd0);
      #1 sample_en = 1'b0;
      repeat (5) @(posedge core_clk);
      for (int i = 1; i <= 3; i++) send(DW'(16'h5A00 + i), 1'b0, 1'b0);
      stop_stream();
      repeat (12) @(negedge core_clk);
      chk("t5a_nodone", AW'(done_cnt), 32'd0);
      chk("t5a_trp", trig_real_pos, 32'd2);
      chk("t5a_saddr", sd_saddr, 32'd0);
      end_cap();

      // latency with trig_dly=5
      trig_dly = 4'd5;
      repeat (20) @(posedge core_clk);
      start_cap(32'd100, 32'd0, 1'b1);
      repeat (3) @(posedge core_clk);
      #1;
      last_cap_cyc = -1;
      sample_valid = 1'b1;
      sample_data  = 16'hBEEF;
      c0           = cyc;
      exp_q.push_back(16'hBEEF);
      @(posedge core_clk); #1;
      sample_valid = 1'b0;
      repeat (15) @(negedge core_clk);
      chk("t4_latency", AW'(last_cap_cyc - c0), 32'd9);
      chk("t4_left", AW'(exp_q.size()), 32'd0);
      end_cap();
      trig_dly = 4'd0;
      repeat (20) @(posedge core_clk);

      // async reset while ARMED with a capture on the output
      start_cap(32'd100, 32'd0, 1'b1);
      for (int i = 1; i <= 4; i++) send(DW'(16'h7700 + i), 1'b0, 1'b1);
      stop_stream();
      n = 0;
      while (capture_valid !== 1'b1 && n < 20) begin
         @(negedge core_clk);
         n++;
      end
      chk("t5b_seen", AW'(capture_valid), 32'd1);
      #1 core_rst_n = 1'b0;
      sample_en = 1'b0;
      #1;
      chk("t5b_valid", AW'(capture_valid), 32'd0);
      chk("t5b_data", AW'(capture_data), 32'd0);
      chk("t5b_done", AW'(capture_done), 32'd0);
      chk("t5b_trp", trig_real_pos, 32'd0);
      chk("t5b_saddr", sd_saddr, 32'd0);
      exp_q.delete();
      repeat (3) @(posedge core_clk);
      #1 core_rst_n = 1'b1;
      repeat (12) @(negedge core_clk);
      chk("t5b_quiet", AW'(capture_valid), 32'd0);

`ifdef CAPTURE_OVF_EN
      // downstream not ready during a valid capture
      start_cap(32'd100, 32'd0, 1'b1);
      capture_ready = 1'b0;
      send(16'h6001, 1'b0, 1'b1);
      stop_stream();
      repeat (8) @(negedge core_clk);
      chk("t6_ovf_set", AW'(capture_ovf), 32'd1);
      capture_ready = 1'b1;
      repeat (4) @(negedge core_clk);
      chk("t6_ovf_hold", AW'(capture_ovf), 32'd1);
      #1 sample_en = 1'b0;
      repeat (3) @(posedge core_clk);
      #1 sample_en = 1'b1;
      @(posedge core_clk);
      @(negedge core_clk);
      chk("t6_ovf_clr", AW'(capture_ovf), 32'd0);
      end_cap();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
